// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants and helpers for the register-file read-port arbiter.
// Provides operand/address widths, the "not renamed" status value and a slicing helper.
package regfile_read_arbiter_pkg;

    localparam int RegAddrSize = 5;
    localparam int InstSize    = 32;
    localparam logic [31:0] NO_TAG = 32'd1000;

    // Low bit of requester idx's register address inside a packed req_rs* vector.
    function automatic int rs_lsb(input int idx);
        return idx * RegAddrSize;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap-around.
// The pointer register lives in the parent so it can gate updates on stall and flush.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's two read ports among NUM_REQ requesters, one per cycle round-robin,
// and returns the commit-bypassed operands on a registered response bus one cycle later.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               TAG_W   = 32,
    parameter logic [TAG_W-1:0] NO_TAG  = regfile_read_arbiter_pkg::NO_TAG
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           clear,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*RegAddrSize-1:0] req_rs1,
    input  logic [NUM_REQ*RegAddrSize-1:0] req_rs2,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic                           rf_en_1,
    output logic                           rf_en_2,
    output logic [RegAddrSize-1:0]         rf_addr_1,
    output logic [RegAddrSize-1:0]         rf_addr_2,
    input  logic [TAG_W-1:0]               rf_status_1,
    input  logic [TAG_W-1:0]               rf_status_2,
    input  logic [InstSize-1:0]            rf_data_1,
    input  logic [InstSize-1:0]            rf_data_2,
    input  logic                           cm_valid,
    input  logic [RegAddrSize-1:0]         cm_addr,
    input  logic [TAG_W-1:0]               cm_tag,
    input  logic [InstSize-1:0]            cm_data,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [InstSize-1:0]            resp_data1,
    output logic [InstSize-1:0]            resp_data2,
    output logic [TAG_W-1:0]               resp_tag1,
    output logic [TAG_W-1:0]               resp_tag2
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;
    logic               grant_ok;
    logic [InstSize-1:0] op1_data, op2_data;
    logic [TAG_W-1:0]    op1_tag, op2_tag;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign grant_ok  = rst_in && rdy_in && !clear && arb_any;
    assign req_grant = grant_ok ? arb_grant : '0;

    // x0 reads as zero; a commit to the same register whose tag matches the pending
    // rename supplies the value the register file has not yet written.
    function automatic void resolve(
        input  logic [RegAddrSize-1:0] addr,
        input  logic [TAG_W-1:0]       status,
        input  logic [InstSize-1:0]    data,
        output logic [InstSize-1:0]    o_data,
        output logic [TAG_W-1:0]       o_tag
    );
        o_data = data;
        o_tag  = status;
        if (addr == '0) begin
            o_data = '0;
            o_tag  = NO_TAG;
        end else if (cm_valid && cm_addr == addr && status == cm_tag) begin
            o_data = cm_data;
            o_tag  = NO_TAG;
        end
    endfunction

    always_comb begin
        rf_en_1   = grant_ok;
        rf_en_2   = grant_ok;
        rf_addr_1 = '0;
        rf_addr_2 = '0;
        if (grant_ok) begin
            rf_addr_1 = req_rs1[rs_lsb(int'(arb_idx)) +: RegAddrSize];
            rf_addr_2 = req_rs2[rs_lsb(int'(arb_idx)) +: RegAddrSize];
        end
        resolve(rf_addr_1, rf_status_1, rf_data_1, op1_data, op1_tag);
        resolve(rf_addr_2, rf_status_2, rf_data_2, op2_data, op2_tag);
    end

    // rdy_in low freezes everything, including a visible response; clear only acts when ready.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr     <= '0;
            resp_valid <= '0;
            resp_data1 <= '0;
            resp_data2 <= '0;
            resp_tag1  <= NO_TAG;
            resp_tag2  <= NO_TAG;
        end else if (rdy_in) begin
            if (grant_ok) begin
                resp_valid <= arb_grant;
                resp_data1 <= op1_data;
                resp_data2 <= op2_data;
                resp_tag1  <= op1_tag;
                resp_tag2  <= op2_tag;
                rr_ptr     <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end else begin
                resp_valid <= '0;
            end
        end
    end

endmodule
